// File: rtl/t10_keypad_scanner.sv
// 4x4 keypad column scanner with row resync and whole-scan debounce.
// Ports: clk, rst (async high), en, row_sense[3:0] in; col_drive[3:0], cur_key[7:0], strobe out.
module t10_keypad_scanner #(
  parameter int SCAN_CYCLES    = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [7:0] cur_key,
  output logic       strobe
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    PEND_PRESS,
    PRESSED,
    PEND_RELEASE
  } state_t;

  logic [3:0]       sync1;
  logic [3:0]       row_s;
  logic [SW-1:0]    slot;
  logic [3:0][3:0]  hits;
  logic [3:0][3:0]  hn;
  state_t           state;
  logic [7:0]       cand;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic             slot_last;
  logic             scan_end;
  logic [2:0]       ncol;
  logic [7:0]       scan_key;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      row_s <= '0;
    end else begin
      sync1 <= row_sense;
      row_s <= sync1;
    end
  end

  assign slot_last = (slot == SLOT_LAST) && (col_drive != 4'b0000);
  assign scan_end  = slot_last && col_drive[0];
  assign cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  // hits is indexed by col_drive bit, so the column code of a hit
  // is simply the one-hot of its index. The current sample is folded
  // in here so scan end sees the C3 column too.
  always_comb begin
    hn       = hits;
    ncol     = 3'd0;
    scan_key = 8'h00;
    for (int b = 0; b < 4; b++) begin
      if (slot_last && col_drive[b]) hn[b] = hits[b] | row_s;
      if (hn[b] != 4'h0) begin
        ncol = ncol + 3'd1;
        if ((hn[b] & (hn[b] - 4'd1)) == 4'h0)
          scan_key = {hn[b], 4'(1 << b)};
        else
          scan_key = 8'h00;
      end
    end
    if (ncol != 3'd1) scan_key = 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_drive <= 4'b1000;
      slot      <= '0;
      hits      <= '0;
      state     <= IDLE;
      cand      <= 8'h00;
      cnt       <= 4'd0;
      cur_key   <= 8'h00;
      strobe    <= 1'b0;
    end else if (!en) begin
      col_drive <= 4'b0000;
      slot      <= '0;
      hits      <= '0;
      state     <= IDLE;
      cnt       <= 4'd0;
      cur_key   <= 8'h00;
      strobe    <= 1'b0;
    end else if (col_drive == 4'b0000) begin
      col_drive <= 4'b1000;
      slot      <= '0;
    end else begin
      if (slot_last) begin
        slot      <= '0;
        col_drive <= {col_drive[0], col_drive[3:1]};
      end else begin
        slot <= slot + 1'b1;
      end
      hits <= scan_end ? '0 : hn;
      if (scan_end) begin
        unique case (state)
          IDLE: begin
            if (scan_key != 8'h00) begin
              cand <= scan_key;
              cnt  <= 4'd1;
              if (DS == 4'd1) begin
                state   <= PRESSED;
                cur_key <= scan_key;
                strobe  <= 1'b1;
              end else begin
                state <= PEND_PRESS;
              end
            end
          end
          PEND_PRESS: begin
            if (scan_key == 8'h00) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else if (scan_key == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DS) begin
                state   <= PRESSED;
                cur_key <= cand;
                strobe  <= 1'b1;
              end
            end else begin
              cand <= scan_key;
              cnt  <= 4'd1;
            end
          end
          PRESSED: begin
            if (scan_key != cand) begin
              cnt <= 4'd1;
              if (DS == 4'd1) begin
                state   <= IDLE;
                cur_key <= 8'h00;
                strobe  <= 1'b0;
              end else begin
                state <= PEND_RELEASE;
              end
            end
          end
          PEND_RELEASE: begin
            if (scan_key == cand) begin
              state <= PRESSED;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == DS) begin
                state   <= IDLE;
                cur_key <= 8'h00;
                strobe  <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t10_keypad_scanner.sv
// Bench for t10_keypad_scanner: keypad matrix model, scan-level
// debounce reference, per-cycle compare plus directed literal pins.
module tb_t10_keypad_scanner;

  localparam int SC = 4;
  localparam int DS = 3;
  localparam int SCAN = 4 * SC;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] row_sense;
  logic [3:0] col_drive;
  logic [7:0] cur_key;
  logic       strobe;

  t10_keypad_scanner #(
    .SCAN_CYCLES(SC),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .row_sense(row_sense),
    .col_drive(col_drive),
    .cur_key(cur_key),
    .strobe(strobe)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  bit chk_on = 0;

  // pressed bit index = row*4 + col
  logic [15:0] pressed = '0;

  // reference model
  int         ph = 0;
  logic [7:0] m_key = 8'h00;
  logic       m_stb = 1'b0;
  logic [7:0] run_key = 8'h00;
  int         run_len = 0;
  int         miss = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_col();
    if (ph < 0) return 4'h0;
    return 4'h8 >> ((ph / SC) % 4);
  endfunction

  function automatic logic [7:0] scan_of(logic [15:0] m);
    int ncol;
    logic [7:0] k;
    ncol = 0;
    k = 8'h00;
    for (int c = 0; c < 4; c++) begin
      int nr;
      int rr;
      nr = 0;
      rr = 0;
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) begin
          nr++;
          rr = r;
        end
      if (nr > 0) begin
        ncol++;
        k = (nr == 1) ? {4'(8 >> rr), 4'(8 >> c)} : 8'h00;
      end
    end
    return (ncol == 1) ? k : 8'h00;
  endfunction

  task automatic clear_model();
    m_key = 8'h00;
    m_stb = 1'b0;
    run_key = 8'h00;
    run_len = 0;
    miss = 0;
  endtask

  // Press: DS identical nonzero scans in a row while not held.
  // Release: DS scans in a row that differ from the held key.
  task automatic model_scan_end(logic [7:0] sk);
    if (m_stb) begin
      if (sk == m_key) miss = 0;
      else begin
        miss++;
        if (miss >= DS) clear_model();
      end
    end else begin
      if (sk == 8'h00) run_len = 0;
      else if (sk == run_key && run_len > 0) run_len++;
      else begin
        run_key = sk;
        run_len = 1;
      end
      if (run_len >= DS) begin
        m_stb = 1'b1;
        m_key = run_key;
        miss = 0;
      end
    end
  endtask

  task automatic drive_rows();
    logic [3:0] rs;
    rs = 4'h0;
    for (int c = 0; c < 4; c++)
      if (col_drive[3-c])
        for (int r = 0; r < 4; r++)
          if (pressed[r*4+c]) rs[3-r] = 1'b1;
    row_sense = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!en) begin
      ph = -1;
      clear_model();
    end else if (ph < 0) begin
      ph = 0;
    end else begin
      if (ph % SCAN == SCAN - 1) model_scan_end(scan_of(pressed));
      ph++;
    end
    drive_rows();
  endtask

  task automatic scan(logic [15:0] m, int n);
    repeat (n) begin
      pressed = m;
      drive_rows();
      repeat (SCAN) tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ph = 0;
    clear_model();
    #1;
    drive_rows();
    chk("rst_col", {4'h0, col_drive}, 8'h08);
    chk("rst_key", cur_key, 8'h00);
    chk("rst_stb", {7'h0, strobe}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_rows();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("col_drive", {4'h0, col_drive}, {4'h0, exp_col()});
      chk("cur_key", cur_key, m_key);
      chk("strobe", {7'h0, strobe}, {7'h0, m_stb});
    end
  end

  initial begin
    logic [15:0] pat;
    rst = 1'b1;
    en = 1'b1;
    row_sense = 4'h0;
    do_reset();
    chk_on = 1;

    // 1: column rotation
    pressed = '0;
    repeat (SC) tick();
    chk("seq_c1", {4'h0, col_drive}, 8'h04);
    repeat (SC) tick();
    chk("seq_c2", {4'h0, col_drive}, 8'h02);
    repeat (SC) tick();
    chk("seq_c3", {4'h0, col_drive}, 8'h01);
    repeat (SC) tick();
    chk("seq_c0", {4'h0, col_drive}, 8'h08);

    // 2: R2C0 held 5 scans
    scan(16'h0100, 2);
    chk("r2c0_early", {7'h0, strobe}, 8'h00);
    scan(16'h0100, 1);
    chk("r2c0_stb", {7'h0, strobe}, 8'h01);
    chk("r2c0_key", cur_key, 8'h28);
    scan(16'h0100, 2);
    scan(16'h0000, 3);
    chk("r2c0_rel", {7'h0, strobe}, 8'h00);

    // 3: interrupted R3C0 press
    scan(16'h1000, 2);
    scan(16'h0000, 1);
    scan(16'h1000, 2);
    chk("r3c0_early", {7'h0, strobe}, 8'h00);
    scan(16'h1000, 1);
    chk("r3c0_key", cur_key, 8'h18);
    scan(16'h0000, 3);

    // 4: ghosting pair R1C1 + R1C2
    scan(16'h0060, 6);
    chk("ghost_stb", {7'h0, strobe}, 8'h00);
    chk("ghost_key", cur_key, 8'h00);
    scan(16'h0000, 1);

    // 5: release gap shorter than debounce
    scan(16'h0008, 3);
    chk("r0c3_key", cur_key, 8'h81);
    scan(16'h0000, 2);
    chk("gap_hold", {7'h0, strobe}, 8'h01);
    scan(16'h0008, 1);
    scan(16'h0000, 2);
    chk("gap2_hold", cur_key, 8'h81);
    scan(16'h0000, 1);
    chk("gap_rel_stb", {7'h0, strobe}, 8'h00);
    chk("gap_rel_key", cur_key, 8'h00);

    // 6: reset mid-slot while held, then en drop while held
    scan(16'h0100, 3);
    chk("pre_rst_stb", {7'h0, strobe}, 8'h01);
    repeat (5) tick();
    do_reset();
    scan(16'h0100, 3);
    chk("pre_en_stb", {7'h0, strobe}, 8'h01);
    repeat (2) tick();
    en = 1'b0;
    tick();
    chk("en0_col", {4'h0, col_drive}, 8'h00);
    chk("en0_key", cur_key, 8'h00);
    chk("en0_stb", {7'h0, strobe}, 8'h00);
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("en1_col", {4'h0, col_drive}, 8'h08);

    // random patterns with persistence and occasional enable drops
    pat = '0;
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: pat = '0;
          8: pat = (16'h1 << $urandom_range(0, 15)) |
                   (16'h1 << $urandom_range(0, 15));
          9: pat = 16'($urandom) & 16'($urandom);
          default: pat = 16'h1 << $urandom_range(0, 15);
        endcase
      end
      if ($urandom_range(0, 39) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        en = 1'b1;
        tick();
      end
      scan(pat, 1);
    end

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
